bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter. It is the inverse of the binary-to-BCD display path and performs reverse double-dabble: shift right, then subtract 3 from any nibble that is 8 or more. The watch's time-set and alarm-set logic uses it to turn operator-entered BCD digits (minutes, seconds, hours) back into binary counter load values. Conversion is multi-cycle with a start/done handshake, one bit per clock, so the area stays small.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_to_bin_seq_if.sv | 24 ++
 rtl/bcd_nibble_adjust.sv | 18 +
 rtl/bcd_to_bin_seq.sv | 126 ++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the BCD<->binary conversion paths.
package bcd_pkg;

  localparam int BCD_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic bcd_valid(input logic [BCD_NIBBLE_W-1:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/done handshake and data bus of the sequential BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
);

  logic                    start;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    busy;
  logic                    done;
  logic [BIN_W-1:0]        bin_out;
  logic                    err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble correction for one BCD digit: take 3 off any nibble >= 8.
module bcd_nibble_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] nib_i,
  output logic [BCD_NIBBLE_W-1:0] nib_o
);

  // Four-bit wrap is harmless: only validated digits ever reach this path.
  always_comb begin
    if (nib_i >= 4'd8) begin
      nib_o = nib_i - 4'd3;
    end else begin
      nib_o = nib_i;
    end
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one reverse double-dabble shift per clock,
// start/done handshake, invalid digits flagged with err and a zero result.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int BIN_W      = 7
) (
  input logic               clk,
  input logic               rst_n,
  bcd_to_bin_seq_if.slave   bus
);

  localparam int BCD_W = BCD_NIBBLE_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 64'sd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'sd10;
    end
    return r;
  endfunction

  if ((64'sd1 <<< BIN_W) <= (pow10(NUM_DIGITS) - 64'sd1)) begin : g_width_check
    $error("BIN_W too narrow for NUM_DIGITS BCD digits");
  end

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               err_q, err_d;

  logic [BCD_W-1:0]   bcd_shift_s;
  logic [BCD_W-1:0]   bcd_adj_s;
  logic [BIN_W-1:0]   bin_shift_s;
  logic               all_valid_s;

  assign bcd_shift_s = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift_s = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib_i (bcd_shift_s[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .nib_o (bcd_adj_s[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

  // Every input digit must be 0..9 before a conversion is attempted.
  always_comb begin
    all_valid_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_valid_s = all_valid_s & bcd_valid(bus.bcd_in[i*BCD_NIBBLE_W +: BCD_NIBBLE_W]);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d     = bus.bcd_in;
          bin_d     = '0;
          cnt_d     = '0;
          bin_out_d = '0;
          err_d     = ~all_valid_s;
          state_d   = all_valid_s ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj_s;
        bin_d = bin_shift_s;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_SHIFT) begin
          bin_out_d = bin_shift_s;
          state_d   = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy    = (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.bin_out = bin_out_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: driver queues expected results, monitor checks each done pulse.
module tb_bcd_to_bin_seq;

  typedef struct {
    logic [6:0] bin;
    logic       err;
    int         cyc;
    int         busy;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   busy_cnt;
  exp_t sb[$];

  bcd_to_bin_seq_if #(.NUM_DIGITS(2), .BIN_W(7)) bus ();

  bcd_to_bin_seq #(.NUM_DIGITS(2), .BIN_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            check("bin_out", int'(bus.bin_out), int'(e.bin));
            check("err", int'(bus.err), int'(e.err));
            check("done_cycle", cyc, e.cyc);
            check("busy_cycles", busy_cnt, e.busy);
            check("busy_with_done", int'(bus.busy), 0);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic push_exp(input logic [6:0] b, input logic er, input int base);
    exp_t e;
    e.bin  = b;
    e.err  = er;
    e.cyc  = base + (er ? 1 : 8);
    e.busy = er ? 0 : 7;
    sb.push_back(e);
  endtask

  // Issue one start pulse from IDLE; bcd_in is scrambled after the accepting edge.
  task automatic issue(input logic [7:0] v, input logic [6:0] b, input logic er);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    push_exp(b, er, cyc);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bcd_in = 8'hC3;
  endtask

  // Wait (bounded) for done, then step into the following IDLE cycle.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_bin_out"}, int'(bus.bin_out), 0);
    check({tag, "_err"}, int'(bus.err), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Directed conversions, including an invalid digit followed by recovery.
    issue(8'h00, 7'd0, 1'b0);   wait_done("t1");
    issue(8'h59, 7'd59, 1'b0);  wait_done("t2a");
    issue(8'h99, 7'd99, 1'b0);  wait_done("t2b");
    issue(8'h3A, 7'd0, 1'b1);   wait_done("t3a");
    issue(8'h12, 7'd12, 1'b0);  wait_done("t3b");

    // Start during SHIFT is ignored.
    issue(8'h45, 7'd45, 1'b0);
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h07;
    @(negedge clk);
    bus.start  = 1'b0;
    wait_done("t4");
    repeat (3) @(negedge clk);

    // start held high: back-to-back conversions nine cycles apart.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h23;
    push_exp(7'd23, 1'b0, cyc);
    push_exp(7'd23, 1'b0, cyc + 9);
    push_exp(7'd23, 1'b0, cyc + 18);
    wait_done("t5a");
    wait_done("t5b");
    wait_done("t5c");
    bus.start = 1'b0;

    // Reset in the fourth SHIFT cycle aborts with no done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 8'h47;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy_before_reset", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("t6_abort");
    repeat (2) @(negedge clk);
    check_zero("t6_held");
    rst_n = 1'b1;
    issue(8'h08, 7'd8, 1'b0);   wait_done("t6b");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
